sr_flop_bank: RTL
=================

# sr_flop_bank

Parametrised, clocked bank of WIDTH independent set/reset storage cells with per-channel enable and a compile-time selectable set/reset-conflict resolution mode. It replaces single-bit level-sensitive SR latches in control paths with edge-triggered, reset-defined state, and reports illegal set-and-reset requests instead of producing X. It sits between control decoders (s/r pulse sources) and the status/flag registers they drive.

## Interface
- WIDTH, 8, number of channels (1..32)
- MODE, 0, s&r conflict resolution: 0 = set-dominant, 1 = reset-dominant, 2 = hold, 3 = toggle
- RST_VAL, {WIDTH{1'b0}}, value of q after reset
- CNT_W, 8, width of conflict event counter
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- s  input  WIDTH  per-channel set request
- r  input  WIDTH  per-channel reset request
- e  input  WIDTH  per-channel enable; channel ignores s/r when low
- conflict_clr  input  1  synchronous clear of conflict flags and counter
- q  output  WIDTH  stored state
- q_bar  output  WIDTH  combinational ~q
- conflict  output  WIDTH  sticky per-channel flag: s&r seen while enabled
- conflict_cnt  output  CNT_W  cycles with at least one conflict (present only with macro)

## Operation
- Per channel i at each rising clk, next q[i]:
  - e[i]=0: hold
  - s=0,r=0: hold; s=1,r=0: 1; s=0,r=1: 0
  - s=1,r=1: per MODE (1 / 0 / hold / ~q[i])
- No X is ever generated; all four s/r combinations are defined.
- conflict[i] sets on a clock where e[i]&s[i]&r[i]; stays set until conflict_clr.
- conflict_clr and a new conflict on the same clock: the flag ends set (new event wins).
- conflict_clr does not affect q.
- Counter: increments on every clock where |(e&s&r) is true; saturates at all-ones, no wrap.
- Counter with conflict_clr and a conflict on the same clock: result is 1. conflict_clr alone: 0.
- Illegal MODE values (>3) resolve as MODE 2 (hold).

## Timing
- Reset (asynchronous assert, any time, including mid-operation): q=RST_VAL, q_bar=~RST_VAL, conflict=0, conflict_cnt=0, immediately and independently of clk.
- Reset release is consumed synchronously. The first clock with rst_n high applies s/r normally.
- Latency: s/r/e sampled at edge N; q, conflict and counter valid after edge N. One-cycle latency, no bypass.
- q_bar follows q combinationally, zero cycles.
- Single-cycle s/r pulses are sufficient; no minimum pulse width beyond setup/hold.
- All outputs change only on the clk edge or on rst_n assertion.

## Configuration
- SR_FLOP_BANK_CONFLICT_CNT_EN defined: conflict_cnt port and saturating counter are present as specified.
- Undefined: the conflict_cnt port is removed, with no counter logic. The conflict flags and all q behaviour are unchanged.

## Structure
- Package sr_flop_bank_pkg:
  - MODE encodings as named localparams or enum: SR_SET_DOM, SR_RST_DOM, SR_HOLD, SR_TOGGLE
  - shared next-state function taking (q, s, r, e, mode)
- Sub-module sr_cell: one channel holding the q flop and the conflict flag, instantiated WIDTH times in a generate loop.
- The counter and the OR-reduction of conflicts live in the top level, guarded by the macro.

## Test plan
- Reset with RST_VAL=4'b1010 and WIDTH=4, then hold rst_n low across several clocks -> q=1010, q_bar=0101, conflict=0, cnt=0 throughout.
- e=1111, s=0011, r=1100 for one clock from q=0000 -> q=0011 next edge. Then s=r=0 for 3 clocks -> q remains 0011.
- e=0101, s=1111, r=0 from q=0000 -> q=0101, with channels 1 and 3 unchanged.
- Each MODE (0..3) from q=0101, e=1111, s=r=1111 -> q = 1111 / 0000 / 0101 / 1010; conflict=1111; cnt=1.
- CNT_W=2 with macro, 5 consecutive conflict clocks -> cnt=3 saturated. conflict_clr together with a conflict -> cnt=1 and flag set. conflict_clr alone -> cnt=0, conflict=0, q unchanged.
- Assert rst_n mid-stream between edges while q=1111 -> q=RST_VAL immediately. Release rst_n, and the first edge with s=0001 -> q=RST_VAL|0001.

Source files
------------

// File: rtl/sr_flop_bank_pkg.sv
// Shared definitions for the sr_flop_bank set/reset storage bank:
// conflict-resolution mode encodings, MODE decoding and the per-channel
// next-state function used by every storage cell.
package sr_flop_bank_pkg;

  // Resolution applied when set and reset are both requested on an enabled channel
  typedef enum logic [1:0] {
    SR_SET_DOM = 2'd0,
    SR_RST_DOM = 2'd1,
    SR_HOLD    = 2'd2,
    SR_TOGGLE  = 2'd3
  } sr_mode_e;

  // Map the integer MODE parameter onto an encoding; anything unknown holds
  function automatic sr_mode_e sr_mode_decode(input int mode);
    sr_mode_e res;
    if (mode == 32'sd0) begin
      res = SR_SET_DOM;
    end else if (mode == 32'sd1) begin
      res = SR_RST_DOM;
    end else if (mode == 32'sd3) begin
      res = SR_TOGGLE;
    end else begin
      res = SR_HOLD;
    end
    return res;
  endfunction

  // An enabled channel asking for set and reset at once
  function automatic logic sr_conflict(input logic s, input logic r, input logic e);
    return e & s & r;
  endfunction

  // Next stored value of one channel; every input combination is defined
  function automatic logic sr_next_q(input logic q, input logic s, input logic r,
                                     input logic e, input sr_mode_e mode);
    logic nxt;
    nxt = q;
    if (!e) begin
      nxt = q;
    end else begin
      case ({s, r})
        2'b00: nxt = q;
        2'b10: nxt = 1'b1;
        2'b01: nxt = 1'b0;
        2'b11: begin
          case (mode)
            SR_SET_DOM: nxt = 1'b1;
            SR_RST_DOM: nxt = 1'b0;
            SR_HOLD:    nxt = q;
            SR_TOGGLE:  nxt = ~q;
            default:    nxt = q;
          endcase
        end
        default: nxt = q;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// One set/reset storage channel: the q flop plus its sticky conflict flag.
// The conflict flag is cleared by conflict_clr unless a new conflict arrives
// on the same clock, in which case the new event wins.
module sr_cell
  import sr_flop_bank_pkg::*;
#(
  parameter logic     RST_VAL = 1'b0,
  parameter sr_mode_e MODE    = SR_SET_DOM
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  input  logic r,
  input  logic e,
  input  logic conflict_clr,
  output logic q,
  output logic conflict
);

  logic q_r;
  logic conflict_r;
  logic q_nxt_s;
  logic conflict_nxt_s;
  logic hit_s;

  assign hit_s = sr_conflict(s, r, e);

  // Next-state decode for the stored bit and the sticky conflict flag
  always_comb begin
    q_nxt_s        = sr_next_q(q_r, s, r, e, MODE);
    conflict_nxt_s = conflict_r;
    if (hit_s) begin
      conflict_nxt_s = 1'b1;
    end else if (conflict_clr) begin
      conflict_nxt_s = 1'b0;
    end else begin
      conflict_nxt_s = conflict_r;
    end
  end

  // State registers with asynchronous reset to the configured value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r        <= RST_VAL;
      conflict_r <= 1'b0;
    end else begin
      q_r        <= q_nxt_s;
      conflict_r <= conflict_nxt_s;
    end
  end

  assign q        = q_r;
  assign conflict = conflict_r;

endmodule

// File: rtl/sr_flop_bank.sv
// sr_flop_bank: WIDTH independent edge-triggered set/reset cells with
// per-channel enable and compile-time conflict resolution (MODE).
// Optional feature macro: SR_FLOP_BANK_CONFLICT_CNT_EN adds the conflict_cnt
// port and a saturating count of clocks that saw at least one conflict.
module sr_flop_bank
  import sr_flop_bank_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               MODE    = 0,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] e,
  input  logic             conflict_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] conflict
`ifdef SR_FLOP_BANK_CONFLICT_CNT_EN
  ,
  output logic [CNT_W-1:0] conflict_cnt
`endif
);

  // Illegal MODE values fall back to hold inside the decoder
  localparam sr_mode_e MODE_RES = sr_mode_decode(MODE);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(
      .RST_VAL (RST_VAL[i]),
      .MODE    (MODE_RES)
    ) u_cell (
      .clk          (clk),
      .rst_n        (rst_n),
      .s            (s[i]),
      .r            (r[i]),
      .e            (e[i]),
      .conflict_clr (conflict_clr),
      .q            (q[i]),
      .conflict     (conflict[i])
    );
  end

  assign q_bar = ~q;

`ifdef SR_FLOP_BANK_CONFLICT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [WIDTH-1:0] hit_s;
  logic             any_hit_s;

  assign hit_s     = e & s & r;
  assign any_hit_s = |hit_s;

  // Saturating counter; a clear on a conflict clock restarts the count at one
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (conflict_clr) begin
      if (any_hit_s) begin
        cnt_nxt_s = CNT_ONE;
      end else begin
        cnt_nxt_s = {CNT_W{1'b0}};
      end
    end else if (any_hit_s && (cnt_r != CNT_MAX)) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Counter register, cleared by the asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign conflict_cnt = cnt_r;
`else
  // Counter build option disabled: only per-channel conflict flags exist.
`endif

endmodule
